// File: rtl/emif_calbus_responder.sv
// Calbus tile-side responder: 128-word sequencer parameter table, ID/SCRATCH/STATUS/CTRL
// registers, fixed-latency read return pipeline and a saturating protocol-error counter.
module emif_calbus_responder #(
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] ID_VALUE   = 32'h0E1F_0261
) (
  input  logic          calbus_clk,
  input  logic          calbus_reset,
  input  logic          calbus_read,
  input  logic          calbus_write,
  input  logic [19:0]   calbus_address,
  input  logic [31:0]   calbus_wdata,
  output logic [31:0]   calbus_rdata,
  output logic          calbus_rdata_valid,
  output logic [4095:0] calbus_seq_param_tbl,
  output logic          cal_done,
  output logic          cal_fail,
  output logic [15:0]   err_count
);

  logic [31:0] tbl [128];
  logic [31:0] scratch;
  logic [31:0] rd_mux;
  logic        page0, hit_tbl, hit_id, hit_scr, hit_sts, hit_ctrl, unmapped;
  logic        err_evt, ctrl_wr;

  logic [31:0] pipe_data [RD_LATENCY];
  logic        pipe_vld  [RD_LATENCY];

  assign page0    = (calbus_address[19:8] == 12'h000);
  assign hit_tbl  = page0 && !calbus_address[7];
  assign hit_id   = page0 && (calbus_address[7:0] == 8'h80);
  assign hit_scr  = page0 && (calbus_address[7:0] == 8'h81);
  assign hit_sts  = page0 && (calbus_address[7:0] == 8'h82);
  assign hit_ctrl = page0 && (calbus_address[7:0] == 8'h83);
  assign unmapped = !(hit_tbl || hit_id || hit_scr || hit_sts || hit_ctrl);
  assign ctrl_wr  = calbus_write && hit_ctrl;

  // At most one error per cycle, whichever conditions overlap.
  assign err_evt = (calbus_read && calbus_write)
                || ((calbus_read || calbus_write) && unmapped)
                || (calbus_write && (hit_id || hit_sts));

  // Read mux sees pre-write register values, giving read-before-write.
  always_comb begin
    rd_mux = 32'h0BAD_0000 | {16'h0000, calbus_address[15:0]};
    if (hit_tbl)       rd_mux = tbl[calbus_address[6:0]];
    else if (hit_id)   rd_mux = ID_VALUE;
    else if (hit_scr)  rd_mux = scratch;
    else if (hit_sts)  rd_mux = {cal_done, cal_fail, 14'b0, err_count};
    else if (hit_ctrl) rd_mux = 32'h0000_0000;
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      for (int i = 0; i < 128; i++) tbl[i] <= 32'h0;
      scratch <= 32'h0;
    end else if (calbus_write) begin
      if (hit_tbl) tbl[calbus_address[6:0]] <= calbus_wdata;
      if (hit_scr) scratch <= calbus_wdata;
    end
  end

  always_comb begin
    calbus_seq_param_tbl = '0;
    for (int i = 0; i < 128; i++) calbus_seq_param_tbl[32*i +: 32] = tbl[i];
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      cal_done  <= 1'b0;
      cal_fail  <= 1'b0;
      err_count <= 16'h0;
    end else begin
      if (ctrl_wr && calbus_wdata[0]) cal_done <= 1'b1;
      if (ctrl_wr && calbus_wdata[1]) cal_fail <= 1'b1;
      if (ctrl_wr && calbus_wdata[31])
        err_count <= 16'h0;
      else if (err_evt && (err_count != 16'hFFFF))
        err_count <= err_count + 16'h1;
    end
  end

  // Data stages carry no reset; only the valid bits need flushing.
  always_ff @(posedge calbus_clk) begin
    pipe_data[0] <= rd_mux;
    for (int k = 1; k < RD_LATENCY; k++) pipe_data[k] <= pipe_data[k-1];
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      for (int k = 0; k < RD_LATENCY; k++) pipe_vld[k] <= 1'b0;
      calbus_rdata_valid <= 1'b0;
      calbus_rdata       <= 32'h0;
    end else begin
      pipe_vld[0] <= calbus_read;
      for (int k = 1; k < RD_LATENCY; k++) pipe_vld[k] <= pipe_vld[k-1];
      calbus_rdata_valid <= pipe_vld[RD_LATENCY-1];
      if (pipe_vld[RD_LATENCY-1]) calbus_rdata <= pipe_data[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_emif_calbus_responder.sv
// Bench for emif_calbus_responder: three instances (latency 1, 3, 4) share stimulus and
// are compared against a register-map level model with a read-return history.
module tb_emif_calbus_responder;
  localparam logic [31:0] ID = 32'h0E1F_0261;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0]   rdata_o [3];
  logic          valid_o [3];
  logic [4095:0] tbl_o   [3];
  logic          done_o  [3];
  logic          fail_o  [3];
  logic [15:0]   err_o   [3];

  emif_calbus_responder #(.RD_LATENCY(1)) u_l1 (
    .calbus_clk(clk), .calbus_reset(rst), .calbus_read(rd), .calbus_write(wr),
    .calbus_address(addr), .calbus_wdata(wdata), .calbus_rdata(rdata_o[0]),
    .calbus_rdata_valid(valid_o[0]), .calbus_seq_param_tbl(tbl_o[0]),
    .cal_done(done_o[0]), .cal_fail(fail_o[0]), .err_count(err_o[0]));
  emif_calbus_responder #(.RD_LATENCY(3)) u_l3 (
    .calbus_clk(clk), .calbus_reset(rst), .calbus_read(rd), .calbus_write(wr),
    .calbus_address(addr), .calbus_wdata(wdata), .calbus_rdata(rdata_o[1]),
    .calbus_rdata_valid(valid_o[1]), .calbus_seq_param_tbl(tbl_o[1]),
    .cal_done(done_o[1]), .cal_fail(fail_o[1]), .err_count(err_o[1]));
  emif_calbus_responder #(.RD_LATENCY(4)) u_l4 (
    .calbus_clk(clk), .calbus_reset(rst), .calbus_read(rd), .calbus_write(wr),
    .calbus_address(addr), .calbus_wdata(wdata), .calbus_rdata(rdata_o[2]),
    .calbus_rdata_valid(valid_o[2]), .calbus_seq_param_tbl(tbl_o[2]),
    .cal_done(done_o[2]), .cal_fail(fail_o[2]), .err_count(err_o[2]));

  // Reference model state
  logic [31:0] m_tbl [128];
  logic [31:0] m_scratch;
  logic        m_done, m_fail;
  logic [15:0] m_err;
  bit          h_rd  [8];
  logic [31:0] h_val [8];
  bit          exp_v [3];
  logic [31:0] exp_d [3];
  int cyc = 0;
  int total = 0, bad = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [19:0] a);
    if (a < 20'h80) return m_tbl[a[6:0]];
    case (a)
      20'h80:  return ID;
      20'h81:  return m_scratch;
      20'h82:  return {m_done, m_fail, 14'b0, m_err};
      20'h83:  return 32'h0;
      default: return 32'h0BAD_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  function automatic logic [4095:0] m_flat();
    logic [4095:0] f;
    for (int i = 0; i < 128; i++) f[32*i +: 32] = m_tbl[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_tbl[i] = 32'h0;
    m_scratch = 0; m_done = 0; m_fail = 0; m_err = 0;
    for (int i = 0; i < 8; i++) begin h_rd[i] = 0; h_val[i] = 0; end
    for (int k = 0; k < 3; k++) begin exp_v[k] = 0; exp_d[k] = 0; end
  endtask

  // One bus cycle: drive at negedge, advance the model at posedge, settle 1ns.
  task automatic cycle(input bit r, input bit w, input logic [19:0] a,
                       input logic [31:0] d, input bit rs);
    logic [31:0] v;
    bit mapped, e;
    int L;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; rst = rs;
    @(posedge clk);
    cyc++;
    if (rs) m_reset();
    else begin
      v = m_read(a);
      mapped = (a < 20'h84);
      e = (r && w) || ((r || w) && !mapped) || (w && (a == 20'h80 || a == 20'h82));
      h_rd[cyc % 8] = r; h_val[cyc % 8] = v;
      if (w) begin
        if (a < 20'h80) m_tbl[a[6:0]] = d;
        if (a == 20'h81) m_scratch = d;
        if (a == 20'h83 && d[0]) m_done = 1;
        if (a == 20'h83 && d[1]) m_fail = 1;
      end
      if (w && a == 20'h83 && d[31]) m_err = 0;
      else if (e && m_err != 16'hFFFF) m_err = m_err + 1;
      for (int k = 0; k < 3; k++) begin
        L = lat_of(k);
        if (cyc >= L && h_rd[(cyc - L) % 8]) begin
          exp_v[k] = 1; exp_d[k] = h_val[(cyc - L) % 8];
        end else exp_v[k] = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 20'h0, 32'h0, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, 20'h0, 32'h0, 1);
    cycle(0, 0, 20'h0, 32'h0, 1);
    for (int k = 0; k < 3; k++) begin
      total++; if (rdata_o[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata L%0d got %h want 0", lat_of(k), rdata_o[k]); end
      total++; if (valid_o[k] !== 1'b0) begin bad++; $display("FAIL reset_valid L%0d got %b want 0", lat_of(k), valid_o[k]); end
      total++; if ({done_o[k], fail_o[k]} !== 2'b00) begin bad++; $display("FAIL reset_flags L%0d got %b%b want 00", lat_of(k), done_o[k], fail_o[k]); end
      total++; if (err_o[k] !== 16'h0) begin bad++; $display("FAIL reset_err L%0d got %h want 0", lat_of(k), err_o[k]); end
      total++; if (tbl_o[k] !== '0) begin bad++; $display("FAIL reset_tbl L%0d got nonzero want 0", lat_of(k)); end
    end
  endtask

  task automatic test_id_read();
    cycle(1, 0, 20'h80, 32'h0, 0);
    total++; if (valid_o[0] !== 1'b0) begin bad++; $display("FAIL id_early_valid got %b want 0", valid_o[0]); end
    idle();
    total++; if (valid_o[0] !== 1'b1 || rdata_o[0] !== ID) begin bad++; $display("FAIL id_read got v=%b d=%h want v=1 d=%h", valid_o[0], rdata_o[0], ID); end
    total++; if (err_o[0] !== 16'h0) begin bad++; $display("FAIL id_err got %h want 0", err_o[0]); end
    for (int j = 0; j < 4; j++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        total++; if (valid_o[k] !== exp_v[k] || rdata_o[k] !== exp_d[k]) begin bad++; $display("FAIL id_ret L%0d got v=%b d=%h want v=%b d=%h", lat_of(k), valid_o[k], rdata_o[k], exp_v[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_tbl_rw();
    cycle(0, 1, 20'h5, 32'hA5A5_1234, 0);
    for (int k = 0; k < 3; k++) begin
      total++; if (tbl_o[k][191:160] !== 32'hA5A5_1234) begin bad++; $display("FAIL tbl5_out L%0d got %h want a5a51234", lat_of(k), tbl_o[k][191:160]); end
    end
    cycle(1, 0, 20'h5, 32'h0, 0);
    for (int j = 0; j < 5; j++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (valid_o[k] !== (j == lat_of(k) - 1) || (j == lat_of(k) - 1 && rdata_o[k] !== 32'hA5A5_1234)) begin
          bad++; $display("FAIL tbl5_ret L%0d step %0d got v=%b d=%h", lat_of(k), j, valid_o[k], rdata_o[k]);
        end
      end
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 20'(i), $urandom, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 20'(i), 32'h0, 0);
      for (int k = 0; k < 3; k++) begin
        total++; if (valid_o[k] !== exp_v[k] || rdata_o[k] !== exp_d[k]) begin bad++; $display("FAIL b2b L%0d got v=%b d=%h want v=%b d=%h", lat_of(k), valid_o[k], rdata_o[k], exp_v[k], exp_d[k]); end
      end
    end
    for (int j = 0; j < 5; j++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        total++; if (valid_o[k] !== exp_v[k] || rdata_o[k] !== exp_d[k]) begin bad++; $display("FAIL b2b_tail L%0d got v=%b d=%h want v=%b d=%h", lat_of(k), valid_o[k], rdata_o[k], exp_v[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_rw_same();
    cycle(0, 0, 20'h0, 32'h0, 1);
    cycle(1, 1, 20'h81, 32'h1, 0);
    for (int j = 0; j < 4; j++) begin
      idle();
      for (int k = 0; k < 3; k++)
        if (j == lat_of(k) - 1) begin
          total++; if (valid_o[k] !== 1'b1 || rdata_o[k] !== 32'h0) begin bad++; $display("FAIL rbw_old L%0d got v=%b d=%h want v=1 d=0", lat_of(k), valid_o[k], rdata_o[k]); end
        end
    end
    cycle(1, 0, 20'h81, 32'h0, 0);
    for (int j = 0; j < 4; j++) begin
      idle();
      for (int k = 0; k < 3; k++)
        if (j == lat_of(k) - 1) begin
          total++; if (valid_o[k] !== 1'b1 || rdata_o[k] !== 32'h1) begin bad++; $display("FAIL rbw_new L%0d got v=%b d=%h want v=1 d=1", lat_of(k), valid_o[k], rdata_o[k]); end
        end
    end
    total++; if (err_o[2] !== 16'h1) begin bad++; $display("FAIL rbw_err got %h want 1", err_o[2]); end
  endtask

  task automatic test_errors();
    cycle(0, 0, 20'h0, 32'h0, 1);
    cycle(1, 0, 20'h12345, 32'h0, 0);
    idle();
    total++; if (rdata_o[0] !== 32'h0BAD_2345) begin bad++; $display("FAIL unmapped_rd got %h want 0bad2345", rdata_o[0]); end
    total++; if (err_o[0] !== 16'h1) begin bad++; $display("FAIL unmapped_err got %h want 1", err_o[0]); end
    cycle(0, 1, 20'h82, 32'hFFFF_FFFF, 0);
    cycle(1, 0, 20'h82, 32'h0, 0);
    idle();
    total++; if (rdata_o[0] !== 32'h0000_0002) begin bad++; $display("FAIL status_ro got %h want 00000002", rdata_o[0]); end
    cycle(0, 1, 20'h80, 32'h0, 0);
    total++; if (err_o[1] !== 16'h3) begin bad++; $display("FAIL id_wr_err got %h want 3", err_o[1]); end
    cycle(0, 1, 20'h83, 32'h8000_0000, 0);
    total++; if (err_o[1] !== 16'h0) begin bad++; $display("FAIL ctrl_clr got %h want 0", err_o[1]); end
    cycle(1, 0, 20'h00100, 32'h0, 0);
    cycle(1, 1, 20'h83, 32'h8000_0000, 0);
    total++; if (err_o[2] !== 16'h0) begin bad++; $display("FAIL clr_wins got %h want 0", err_o[2]); end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 20'h0, 32'h0, 1);
    for (int i = 0; i < 65534; i++) cycle(0, 1, 20'hFFFFF, 32'h0, 0);
    total++; if (err_o[0] !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got %h want fffe", err_o[0]); end
    cycle(0, 1, 20'hFFFFF, 32'h0, 0);
    total++; if (err_o[0] !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got %h want ffff", err_o[0]); end
    cycle(1, 0, 20'h00200, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      total++; if (err_o[k] !== 16'hFFFF) begin bad++; $display("FAIL sat_hold L%0d got %h want ffff", lat_of(k), err_o[k]); end
    end
  endtask

  task automatic test_flags_reset();
    cycle(0, 0, 20'h0, 32'h0, 1);
    cycle(0, 1, 20'h83, 32'h3, 0);
    total++; if (done_o[0] !== 1'b1 || fail_o[0] !== 1'b1) begin bad++; $display("FAIL flags_set got %b%b want 11", done_o[0], fail_o[0]); end
    cycle(0, 1, 20'h83, 32'h0, 0);
    cycle(1, 0, 20'h82, 32'h0, 0);
    idle();
    total++; if (rdata_o[0] !== 32'hC000_0000) begin bad++; $display("FAIL status_flags got %h want c0000000", rdata_o[0]); end
    cycle(1, 0, 20'h80, 32'h0, 0);
    cycle(0, 0, 20'h0, 32'h0, 1);
    for (int j = 0; j < 6; j++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (valid_o[k] !== 1'b0 || rdata_o[k] !== 32'h0 || done_o[k] !== 1'b0 || fail_o[k] !== 1'b0 || err_o[k] !== 16'h0) begin
          bad++; $display("FAIL flush L%0d step %0d got v=%b d=%h f=%b%b e=%h want all 0", lat_of(k), j, valid_o[k], rdata_o[k], done_o[k], fail_o[k], err_o[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] a;
    logic [31:0] d;
    for (int n = 0; n < 800; n++) begin
      case ($urandom % 8)
        0, 1, 2, 3: a = 20'($urandom % 128);
        4:          a = 20'h80 + 20'($urandom % 4);
        5:          a = 20'h84 + 20'($urandom % 124);
        6:          a = 20'($urandom);
        default:    a = 20'h81;
      endcase
      d = $urandom;
      cycle(1'($urandom), ($urandom % 3) == 0, a, d, ($urandom % 64) == 0);
      for (int k = 0; k < 3; k++) begin
        total++; if (valid_o[k] !== exp_v[k] || rdata_o[k] !== exp_d[k]) begin bad++; $display("FAIL rnd_ret L%0d cyc %0d got v=%b d=%h want v=%b d=%h", lat_of(k), cyc, valid_o[k], rdata_o[k], exp_v[k], exp_d[k]); end
        total++; if (err_o[k] !== m_err || done_o[k] !== m_done || fail_o[k] !== m_fail) begin bad++; $display("FAIL rnd_stat L%0d cyc %0d got e=%h f=%b%b want e=%h f=%b%b", lat_of(k), cyc, err_o[k], done_o[k], fail_o[k], m_err, m_done, m_fail); end
      end
      if (n % 16 == 0) begin
        total++; if (tbl_o[1] !== m_flat()) begin bad++; $display("FAIL rnd_tbl cyc %0d got table differs from model", cyc); end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_id_read();
    test_tbl_rw();
    test_rw_same();
    test_errors();
    test_flags_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
